// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array support blocks.
package systolic_pkg;

    // Drain controller states
    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,
        DRAIN_BUSY = 2'd1,
        DRAIN_DONE = 2'd2
    } drain_state_t;

    // Default array dimension and the matching index width
    localparam int SIZE_DEFAULT = 4;
    localparam int IDX_BITS     = $clog2(SIZE_DEFAULT);

endpackage

// File: rtl/systolic_idx_counter.sv
// Row-major 2-D index counter {row, col} over a SIZE x SIZE array.
// Clear has priority over enable; col increments and carries into row,
// and at_last flags the terminal element (SIZE-1, SIZE-1).
module systolic_idx_counter
    import systolic_pkg::*;
#(
    parameter int SIZE = SIZE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    output logic [$clog2(SIZE)-1:0] row,
    output logic [$clog2(SIZE)-1:0] col,
    output logic                    at_last
);

    localparam int              IW      = $clog2(SIZE);
    localparam logic [IW-1:0]   IDX_MAX = IW'(SIZE - 1);

    logic [IW-1:0] row_next;
    logic [IW-1:0] col_next;

    // Next index: clear, or step col with carry into row
    always_comb begin
        row_next = row;
        col_next = col;
        if (clr) begin
            row_next = '0;
            col_next = '0;
        end else if (en) begin
            if (col == IDX_MAX) begin
                col_next = '0;
                row_next = (row == IDX_MAX) ? '0 : row + 1'b1;
            end else begin
                col_next = col + 1'b1;
            end
        end
    end

    // Index registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else begin
            row <= row_next;
            col <= col_next;
        end
    end

    assign at_last = (row == IDX_MAX) && (col == IDX_MAX);

endmodule

// File: rtl/systolic_drain.sv
// Result-drain stage: walks the array's output selects in row-major order,
// registers each result and streams it out on a val/rdy interface with a
// last marker, then pulses drain_done for one cycle.
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int NBITS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    out_rdy,
    output logic [$clog2(SIZE)-1:0] out_rsel,
    output logic [$clog2(SIZE)-1:0] out_csel,
    input  logic [NBITS-1:0]        b_s_out,
    output logic [NBITS-1:0]        send_msg,
    output logic                    send_val,
    input  logic                    send_rdy,
    output logic                    send_last,
    output logic                    busy,
    output logic                    drain_done
);

    drain_state_t state_reg;
    drain_state_t state_next;

    logic armed_reg;
    logic issued_all_reg;
    logic start;
    logic load;
    logic xfer;
    logic cnt_clr;
    logic cnt_en;
    logic cnt_last;

    // A new element may enter the output register when it is empty or
    // being emptied this cycle, until every element has been issued.
    assign xfer    = send_val && send_rdy;
    assign load    = (state_reg == DRAIN_BUSY) && (!send_val || send_rdy) && !issued_all_reg;
    assign start   = (state_reg == DRAIN_IDLE) && out_rdy && armed_reg;

    // Counter sits at (0,0) outside DRAIN and parks on the last element
    // once it has been loaded, so the selects hold there until DONE.
    assign cnt_clr = (state_reg != DRAIN_BUSY);
    assign cnt_en  = load && !cnt_last;

    systolic_idx_counter #(
        .SIZE (SIZE)
    ) u_idx (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .row     (out_rsel),
        .col     (out_csel),
        .at_last (cnt_last)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= DRAIN_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DRAIN_IDLE: begin
                if (start) begin
                    state_next = DRAIN_BUSY;
                end
            end
            DRAIN_BUSY: begin
                if (xfer && send_last) begin
                    state_next = DRAIN_DONE;
                end
            end
            DRAIN_DONE: begin
                state_next = DRAIN_IDLE;
            end
            default: begin
                state_next = DRAIN_IDLE;
            end
        endcase
    end

    // Arm flag: consumed by a drain start, re-armed once out_rdy is seen low,
    // so a matrix that stays ready is drained only once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_reg <= 1'b1;
        end else if (start) begin
            armed_reg <= 1'b0;
        end else if (!out_rdy) begin
            armed_reg <= 1'b1;
        end
    end

    // Marks that the final element has entered the output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued_all_reg <= 1'b0;
        end else if (state_reg != DRAIN_BUSY) begin
            issued_all_reg <= 1'b0;
        end else if (load && cnt_last) begin
            issued_all_reg <= 1'b1;
        end
    end

    // Output register: load new element, or empty after a plain transfer.
    // Data only changes on load, which cannot happen while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            send_msg  <= '0;
            send_val  <= 1'b0;
            send_last <= 1'b0;
        end else if (load) begin
            send_msg  <= b_s_out;
            send_val  <= 1'b1;
            send_last <= cnt_last;
        end else if (xfer) begin
            send_val  <= 1'b0;
            send_last <= 1'b0;
        end
    end

    assign busy       = (state_reg != DRAIN_IDLE);
    assign drain_done = (state_reg == DRAIN_DONE);

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: SIZE=4 and SIZE=2 instances driven by modelled
// arrays, table-driven drain scenarios, random back-pressure against a
// val/rdy stream model, and hand-written re-drain / reset sequences.
module tb_systolic_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        out_rdy4;
    logic        out_rdy2;
    logic        send_rdy;

    logic [1:0]  rsel4, csel4;
    logic [0:0]  rsel2, csel2;
    logic [15:0] b4, b2, msg4, msg2;
    logic        val4, last4, busy4, done4;
    logic        val2, last2, busy2, done2;

    // Array models: C[r][c] = 16*r + c for SIZE=4, {7,8,9,10} for SIZE=2
    assign b4 = 16'(int'(rsel4) * 16 + int'(csel4));
    assign b2 = 16'(7 + int'(rsel2) * 2 + int'(csel2));

    systolic_drain #(.SIZE(4), .NBITS(16)) dut4 (
        .clk(clk), .rst(rst), .out_rdy(out_rdy4),
        .out_rsel(rsel4), .out_csel(csel4), .b_s_out(b4),
        .send_msg(msg4), .send_val(val4), .send_rdy(send_rdy),
        .send_last(last4), .busy(busy4), .drain_done(done4)
    );

    systolic_drain #(.SIZE(2), .NBITS(16)) dut2 (
        .clk(clk), .rst(rst), .out_rdy(out_rdy2),
        .out_rsel(rsel2), .out_csel(csel2), .b_s_out(b2),
        .send_msg(msg2), .send_val(val2), .send_rdy(send_rdy),
        .send_last(last2), .busy(busy2), .drain_done(done2)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    // Observation helpers selecting one of the two instances
    function automatic logic g_val(input bit u);  return u ? val2  : val4;  endfunction
    function automatic logic g_last(input bit u); return u ? last2 : last4; endfunction
    function automatic logic g_busy(input bit u); return u ? busy2 : busy4; endfunction
    function automatic logic g_done(input bit u); return u ? done2 : done4; endfunction
    function automatic int   g_msg(input bit u);  return u ? int'(msg2) : int'(msg4); endfunction
    function automatic int   g_idx(input bit u);
        return u ? int'(rsel2) * 2 + int'(csel2) : int'(rsel4) * 4 + int'(csel4);
    endfunction

    // Expected k-th streamed element, row-major over the modelled matrix
    function automatic int exp_elem(input bit u, input int k);
        return u ? (7 + k) : (16 * (k / 4) + (k % 4));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete drain. Called 1 time unit after a posedge with the DUT
    // idle and armed; offset 0 is the cycle in which out_rdy is first sampled.
    // The model presents one element per cycle from offset 2, the next one
    // becoming available the cycle after each accepted transfer.
    task automatic run_drain(input bit u, input int mode, input bit hold,
                             input int exp_done, input string name);
        int  n;
        int  avail, mcnt, mdone, dcnt, done_off, exp_i;
        int  bad_val, bad_last, bad_sel, bad_stab, bad_pres, bad_busy;
        bit  r, exp_v, prev_stall;
        int  prev_msg;
        n = u ? 4 : 16;
        avail = 2; mcnt = 0; mdone = -1; dcnt = 0; done_off = -1;
        bad_val = 0; bad_last = 0; bad_sel = 0; bad_stab = 0; bad_pres = 0; bad_busy = 0;
        prev_stall = 1'b0; prev_msg = 0;
        if (u) out_rdy2 = 1'b1; else out_rdy4 = 1'b1;
        for (int o = 0; o < 400 && done_off < 0; o++) begin
            if (o == 1 && !hold) begin
                if (u) out_rdy2 = 1'b0; else out_rdy4 = 1'b0;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (o % 3 == 0);
                2:       r = (o % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            send_rdy = r;
            exp_v = (o >= avail) && (mcnt < n);
            if (g_val(u) !== exp_v) bad_pres++;
            if (prev_stall && (g_msg(u) != prev_msg || g_val(u) !== 1'b1)) bad_stab++;
            if (o >= 1) begin
                exp_i = mcnt + ((o >= 2) ? 1 : 0);
                if (exp_i > n - 1) exp_i = n - 1;
                if (g_idx(u) != exp_i) bad_sel++;
                if (g_busy(u) !== 1'b1) bad_busy++;
            end else if (g_busy(u) !== 1'b0) begin
                bad_busy++;
            end
            if (g_val(u) && g_last(u) !== (dcnt == n - 1)) bad_last++;
            if (g_done(u)) done_off = o;
            if (g_val(u) && r) begin
                $display("%s xfer %0d msg=%0d last=%0b t=%0d", name, dcnt, g_msg(u), g_last(u), o);
                if (g_msg(u) != exp_elem(u, dcnt)) bad_val++;
                dcnt++;
            end
            if (exp_v && r) begin
                mcnt++;
                avail = o + 1;
                if (mcnt == n) mdone = o + 1;
            end
            prev_stall = g_val(u) && !r;
            prev_msg   = g_msg(u);
            step();
        end
        chk({name, "_xfer_count"}, dcnt, n);
        chk({name, "_values"}, bad_val, 0);
        chk({name, "_last_flag"}, bad_last, 0);
        chk({name, "_sel_sweep"}, bad_sel, 0);
        chk({name, "_stable"}, bad_stab, 0);
        chk({name, "_valid"}, bad_pres, 0);
        chk({name, "_busy"}, bad_busy, 0);
        chk({name, "_done_model"}, done_off, mdone);
        if (exp_done >= 0) chk({name, "_done_latency"}, done_off, exp_done);
        // Cycle after DONE: back in IDLE with selects at (0,0), pulse gone
        chk({name, "_idle_after"}, int'({g_busy(u), g_done(u), g_val(u)}), 0);
        chk({name, "_idle_sel"}, g_idx(u), 0);
        $display("%s drain done at offset %0d", name, done_off);
    endtask

    typedef struct {
        string name;
        bit    use2;
        int    mode;
        int    exp_done;
    } drain_vec_t;

    drain_vec_t vecs[5];

    initial begin
        int cnt;
        int bad;
        vecs[0] = '{"full4",   1'b0, 0, 18};
        vecs[1] = '{"bp100_4", 1'b0, 1, 49};
        vecs[2] = '{"bp10_4",  1'b0, 2, 33};
        vecs[3] = '{"full2",   1'b1, 0, 6};
        vecs[4] = '{"bp100_2", 1'b1, 1, 13};

        rst = 1'b0; out_rdy4 = 1'b0; out_rdy2 = 1'b0; send_rdy = 1'b0;
        #2;
        chk("reset_dut4", int'({msg4, val4, last4, busy4, done4, rsel4, csel4}), 0);
        chk("reset_dut2", int'({msg2, val2, last2, busy2, done2, rsel2, csel2}), 0);
        step(); step();
        rst = 1'b1;
        step();
        chk("idle_after_reset", int'({busy4, busy2, val4, val2}), 0);

        // Table-driven drain scenarios
        foreach (vecs[i]) begin
            run_drain(vecs[i].use2, vecs[i].mode, 1'b0, vecs[i].exp_done, vecs[i].name);
            step();
        end

        // Random back-pressure against the stream model
        for (int i = 0; i < 4; i++) begin
            run_drain(1'($urandom_range(0, 1)), 3, 1'b0, -1, "rand");
            step();
        end

        // No re-drain while out_rdy stays high
        run_drain(1'b0, 0, 1'b1, 18, "hold");
        bad = 0;
        send_rdy = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (busy4 || val4) bad++;
            step();
        end
        chk("no_redrain", bad, 0);
        out_rdy4 = 1'b0;
        step();
        run_drain(1'b0, 0, 1'b1, 18, "redrain");
        out_rdy4 = 1'b0;
        step();

        // Reset after the 5th transfer, out_rdy held high
        out_rdy4 = 1'b1;
        send_rdy = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40 && cnt < 5; i++) begin
            if (val4 && send_rdy) cnt++;
            step();
        end
        chk("pre_reset_xfers", cnt, 5);
        rst = 1'b0;
        #1;
        chk("midreset_outputs", int'({msg4, val4, last4, busy4, done4, rsel4, csel4}), 0);
        step();
        chk("midreset_held", int'({msg4, val4, last4, busy4, done4, rsel4, csel4}), 0);
        rst = 1'b1;
        run_drain(1'b0, 0, 1'b1, 18, "after_reset");
        out_rdy4 = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
